uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 35 +++
 rtl/sat_cnt8.sv | 28 ++
 rtl/uart_cmd_parser.sv | 145 ++++++++++++++
 tb/tb_uart_cmd_parser.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser and its command consumer:
// frame marker, parser state encodings and TFT opcode values.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_OPC  = 3'd1;
    localparam logic [2:0] ST_DHI  = 3'd2;
    localparam logic [2:0] ST_DLO  = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_WAIT = 3'd5;

    typedef enum logic [3:0] {
        OPC_NOP         = 4'h0,
        OPC_BACKLIGHT   = 4'h1,
        OPC_ROW_S       = 4'h2,
        OPC_COL_S       = 4'h3,
        OPC_DIS_PAGE    = 4'h4,
        OPC_PAGE_NO     = 4'h5,
        OPC_ROW_E       = 4'h6,
        OPC_COL_E       = 4'h7,
        OPC_SLEEP       = 4'hB,
        OPC_DISP_MODE   = 4'hC,
        OPC_ADD_PTR_INC = 4'hD,
        OPC_DATA_PTR    = 4'hF
    } tft_opcode_e;

    function automatic logic [7:0] frame_checksum(input logic [3:0] opc,
                                                  input logic [7:0] dhi,
                                                  input logic [7:0] dlo);
        return {4'h0, opc} ^ dhi ^ dlo;
    endfunction

endpackage

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 255 instead of wrapping; synchronous clear.
module sat_cnt8 (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/opcode/data-hi/data-lo/checksum frames from a UART byte stream and
// issues one command strobe per good frame, stalling data commands while FIFO_full.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [3:0]  DATA_OPCODE    = OPC_DATA_PTR
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        FIFO_full,
    output logic        rx_ready,
    output logic [3:0]  user_opcode,
    output logic [15:0] user_data,
    output logic        user_data_update,
    output logic [7:0]  chk_err_cnt,
    output logic [7:0]  ovr_cnt
);

    logic [2:0]  state_q, state_d;
    logic [3:0]  opc_q, opc_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic [31:0] tmo_q, tmo_d;
    logic [3:0]  uopc_q, uopc_d;
    logic [15:0] udata_q, udata_d;
    logic        upd_q, upd_d;
    logic        err_inc, ovr_inc;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        dhi_d   = dhi_q;
        dlo_d   = dlo_q;
        tmo_d   = tmo_q;
        uopc_d  = uopc_q;
        udata_d = udata_q;
        upd_d   = 1'b0;
        err_inc = 1'b0;
        ovr_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_d = ST_OPC;
                end
            end
            ST_OPC, ST_DHI, ST_DLO, ST_CHK: begin
                // An arriving byte always takes priority over an expiring timeout.
                if (rx_valid) begin
                    tmo_d = '0;
                    if (state_q == ST_OPC) begin
                        if (rx_data[7:4] != 4'h0) begin
                            state_d = ST_IDLE;
                            err_inc = 1'b1;
                        end else begin
                            opc_d   = rx_data[3:0];
                            state_d = ST_DHI;
                        end
                    end else if (state_q == ST_DHI) begin
                        dhi_d   = rx_data;
                        state_d = ST_DLO;
                    end else if (state_q == ST_DLO) begin
                        dlo_d   = rx_data;
                        state_d = ST_CHK;
                    end else if (rx_data != frame_checksum(opc_q, dhi_q, dlo_q)) begin
                        state_d = ST_IDLE;
                        err_inc = 1'b1;
                    end else if (opc_q == DATA_OPCODE && FIFO_full) begin
                        state_d = ST_WAIT;
                    end else begin
                        uopc_d  = opc_q;
                        udata_d = {dhi_q, dlo_q};
                        upd_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    tmo_d   = '0;
                    state_d = ST_IDLE;
                    err_inc = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_WAIT: begin
                tmo_d   = '0;
                ovr_inc = rx_valid;
                if (!FIFO_full) begin
                    uopc_d  = opc_q;
                    udata_d = {dhi_q, dlo_q};
                    upd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            dhi_q   <= '0;
            dlo_q   <= '0;
            tmo_q   <= '0;
            uopc_q  <= '0;
            udata_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            dhi_q   <= dhi_d;
            dlo_q   <= dlo_d;
            tmo_q   <= tmo_d;
            uopc_q  <= uopc_d;
            udata_q <= udata_d;
            upd_q   <= upd_d;
        end
    end

    sat_cnt8 u_chk_err_cnt (
        .clk_i (clk),
        .clr_i (~nrst),
        .inc_i (err_inc),
        .cnt_o (chk_err_cnt)
    );

    sat_cnt8 u_ovr_cnt (
        .clk_i (clk),
        .clr_i (~nrst),
        .inc_i (ovr_inc),
        .cnt_o (ovr_cnt)
    );

    assign rx_ready         = (state_q != ST_WAIT);
    assign user_opcode      = uopc_q;
    assign user_data        = udata_q;
    assign user_data_update = upd_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised and directed bench for uart_cmd_parser against a frame-level byte-queue model.
module tb_uart_cmd_parser;

    localparam int TMO = 10;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [3:0] DOPC = 4'hF;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        FIFO_full = 1'b0;
    logic        rx_ready;
    logic [3:0]  user_opcode;
    logic [15:0] user_data;
    logic        user_data_update;
    logic [7:0]  chk_err_cnt;
    logic [7:0]  ovr_cnt;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    bit chk_en = 1'b0;

    uart_cmd_parser #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO),
        .DATA_OPCODE    (DOPC)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .FIFO_full        (FIFO_full),
        .rx_ready         (rx_ready),
        .user_opcode      (user_opcode),
        .user_data        (user_data),
        .user_data_update (user_data_update),
        .chk_err_cnt      (chk_err_cnt),
        .ovr_cnt          (ovr_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: bytes of the frame in progress, plus a held data command awaiting FIFO space.
    logic [7:0]  mbuf[$];
    int          m_idle = 0;
    bit          m_pend = 1'b0;
    logic [3:0]  p_opc = '0;
    logic [15:0] p_data = '0;
    logic [3:0]  m_opc = '0;
    logic [15:0] m_data = '0;
    bit          m_upd = 1'b0;
    int          m_err = 0;
    int          m_ovr = 0;

    function automatic void reject();
        if (m_err < 255) m_err++;
        mbuf.delete();
    endfunction

    always @(posedge clk) begin
        m_upd = 1'b0;
        if (!nrst) begin
            mbuf.delete();
            m_idle = 0;
            m_pend = 1'b0;
            m_opc  = '0;
            m_data = '0;
            m_err  = 0;
            m_ovr  = 0;
        end else if (m_pend) begin
            if (rx_valid && m_ovr < 255) m_ovr++;
            if (!FIFO_full) begin
                m_opc  = p_opc;
                m_data = p_data;
                m_upd  = 1'b1;
                m_pend = 1'b0;
            end
        end else if (mbuf.size() == 0) begin
            if (rx_valid && rx_data == SYNC) begin
                mbuf.push_back(rx_data);
                m_idle = 0;
            end
        end else if (rx_valid) begin
            mbuf.push_back(rx_data);
            m_idle = 0;
            if (mbuf.size() == 2 && mbuf[1][7:4] != 4'h0) begin
                reject();
            end else if (mbuf.size() == 5) begin
                if (mbuf[4] != (mbuf[1] ^ mbuf[2] ^ mbuf[3])) begin
                    reject();
                end else if (mbuf[1][3:0] == DOPC && FIFO_full) begin
                    m_pend = 1'b1;
                    p_opc  = mbuf[1][3:0];
                    p_data = {mbuf[2], mbuf[3]};
                    mbuf.delete();
                end else begin
                    m_opc  = mbuf[1][3:0];
                    m_data = {mbuf[2], mbuf[3]};
                    m_upd  = 1'b1;
                    mbuf.delete();
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) reject();
        end
    end

    always @(negedge clk) begin
        if (user_data_update === 1'b1) pulse_cnt++;
        if (chk_en) begin
            check("rx_ready", 32'(rx_ready), 32'(!m_pend));
            check("user_opcode", 32'(user_opcode), 32'(m_opc));
            check("user_data", 32'(user_data), 32'(m_data));
            check("user_data_update", 32'(user_data_update), 32'(m_upd));
            check("chk_err_cnt", 32'(chk_err_cnt), 32'(m_err));
            check("ovr_cnt", 32'(ovr_cnt), 32'(m_ovr));
        end
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic random_frame(input int kind);
        logic [7:0] opc, hi, lo, ck;
        opc = 8'($urandom_range(0, 15));
        hi  = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
        lo  = 8'($urandom);
        ck  = opc ^ hi ^ lo;
        if (kind == 1) ck = ck ^ 8'(1 << $urandom_range(0, 7));
        if (kind == 2) opc = {4'($urandom_range(1, 15)), opc[3:0]};
        send_byte(SYNC);
        idle($urandom_range(0, 2));
        send_byte(opc);
        idle($urandom_range(0, 2));
        send_byte(hi);
        send_byte(lo);
        idle($urandom_range(0, 3));
        send_byte(ck);
    endtask

    int pc0;

    initial begin
        #1;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        chk_en = 1'b1;
        check("reset_err", 32'(chk_err_cnt), 32'd0);
        check("reset_ready", 32'(rx_ready), 32'd1);

        pc0 = pulse_cnt;
        send5(8'hA5, 8'h01, 8'h00, 8'h07, 8'h06);
        idle(2);
        check("f1_pulses", 32'(pulse_cnt - pc0), 32'd1);
        check("f1_opc", 32'(user_opcode), 32'h1);
        check("f1_data", 32'(user_data), 32'h0007);
        check("f1_cnts", 32'({chk_err_cnt, ovr_cnt}), 32'h0);

        pc0 = pulse_cnt;
        send5(8'hA5, 8'h02, 8'h01, 8'h2C, 8'h2F);
        idle(2);
        check("f2_pulses", 32'(pulse_cnt - pc0), 32'd1);
        check("f2_opc", 32'(user_opcode), 32'h2);
        check("f2_data", 32'(user_data), 32'h012C);
        pc0 = pulse_cnt;
        send5(8'hA5, 8'h02, 8'h01, 8'h2C, 8'h2E);
        idle(2);
        check("badck_pulses", 32'(pulse_cnt - pc0), 32'd0);
        check("badck_err", 32'(chk_err_cnt), 32'd1);
        check("badck_hold", 32'(user_data), 32'h012C);

        // Data command stalled by a full FIFO; 0F^F8^00 = F7.
        FIFO_full = 1'b1;
        pc0 = pulse_cnt;
        send5(8'hA5, 8'h0F, 8'hF8, 8'h00, 8'hF7);
        idle(3);
        check("wait_pulses", 32'(pulse_cnt - pc0), 32'd0);
        check("wait_ready", 32'(rx_ready), 32'd0);
        send_byte(8'h55);
        check("wait_ovr", 32'(ovr_cnt), 32'd1);
        FIFO_full = 1'b0;
        idle(2);
        check("wait_pulses2", 32'(pulse_cnt - pc0), 32'd1);
        check("wait_opc", 32'(user_opcode), 32'hF);
        check("wait_data", 32'(user_data), 32'hF800);

        send_byte(8'hA5);
        send_byte(8'h03);
        idle(TMO);
        check("tmo_err", 32'(chk_err_cnt), 32'd2);
        pc0 = pulse_cnt;
        send5(8'hA5, 8'h05, 8'h12, 8'h34, 8'h23);
        idle(2);
        check("post_tmo_pulse", 32'(pulse_cnt - pc0), 32'd1);
        check("post_tmo_data", 32'(user_data), 32'h1234);
        // Byte arriving on the would-be expiry cycle keeps the frame alive.
        pc0 = pulse_cnt;
        send_byte(8'hA5);
        send_byte(8'h03);
        idle(TMO - 1);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        idle(2);
        check("edge_tmo_pulse", 32'(pulse_cnt - pc0), 32'd1);
        check("edge_tmo_err", 32'(chk_err_cnt), 32'd2);
        check("edge_tmo_data", 32'(user_data), 32'h0001);
        send5(8'hA5, 8'h06, 8'hA5, 8'hA5, 8'h06);
        idle(2);
        check("sync_in_data", 32'(user_data), 32'hA5A5);

        send_byte(8'hA5);
        send_byte(8'h13);
        idle(1);
        check("badopc_err", 32'(chk_err_cnt), 32'd3);
        for (int i = 0; i < 300; i++) begin
            send_byte(8'hA5);
            send_byte(8'h13);
        end
        idle(1);
        check("err_sat", 32'(chk_err_cnt), 32'd255);

        do_reset();
        FIFO_full = 1'b1;
        pc0 = pulse_cnt;
        send5(8'hA5, 8'h0F, 8'h00, 8'h00, 8'h0F);
        for (int i = 0; i < 300; i++) send_byte(8'h00);
        check("ovr_sat", 32'(ovr_cnt), 32'd255);
        FIFO_full = 1'b0;
        idle(2);
        check("ovr_sat_pulse", 32'(pulse_cnt - pc0), 32'd1);
        send5(8'hA5, 8'h07, 8'hBE, 8'hEF, 8'h07 ^ 8'hBE ^ 8'hEF);
        idle(1);

        send_byte(8'hA5);
        send_byte(8'h04);
        do_reset();
        check("rst_opc", 32'(user_opcode), 32'h0);
        check("rst_data", 32'(user_data), 32'h0);
        check("rst_cnts", 32'({chk_err_cnt, ovr_cnt}), 32'h0);
        check("rst_ready", 32'(rx_ready), 32'd1);
        pc0 = pulse_cnt;
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h06);
        idle(3);
        check("rst_trailing", 32'(pulse_cnt - pc0), 32'd0);

        // Randomised traffic; the per-cycle compare against the model does the checking.
        for (int it = 0; it < 1500; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 8) random_frame(0);
            else if (r < 10) random_frame(1);
            else if (r < 11) random_frame(2);
            else if (r < 13) send_byte(($urandom_range(0, 3) == 0) ? SYNC : 8'($urandom));
            else if (r < 15) idle($urandom_range(0, 12));
            else if (r < 18) FIFO_full = 1'($urandom_range(0, 1));
            else if (r < 19) begin
                send_byte(SYNC);
                for (int k = $urandom_range(0, 3); k > 0; k--) send_byte(8'($urandom_range(0, 15)));
                idle($urandom_range(TMO - 1, TMO + 1));
            end else if ($urandom_range(0, 5) == 0) do_reset();
        end
        FIFO_full = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
